// File: rtl/dram_ctrl_pkg.sv
// dram_ctrl_pkg: shared types and helpers for the fast-page DRAM initiator.
//   state_t  - controller state encoding
//   dc_col / dc_row / dc_bank - slice a {bank, row, col} host address.
//     The address is passed zero-extended to 64 bits together with the
//     row/column width so one function serves any AWID/RWID instance.
package dram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROW,
    ST_COL,
    ST_CAS,
    ST_PRE,
    ST_CBR_CAS,
    ST_CBR_RAS
  } state_t;

  function automatic logic [63:0] dc_col(input logic [63:0] a, input int awid);
    return a & ((64'd1 << awid) - 64'd1);
  endfunction

  function automatic logic [63:0] dc_row(input logic [63:0] a, input int awid);
    return (a >> awid) & ((64'd1 << awid) - 64'd1);
  endfunction

  function automatic logic [63:0] dc_bank(input logic [63:0] a, input int awid);
    return a >> (2 * awid);
  endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// dram_refresh_timer: free-running refresh interval counter.
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   ref_take in   controller is starting a CBR refresh this edge
//   ref_pend out  a refresh is owed
// The counter wraps modulo REF_PERIOD; each wrap raises ref_pend. A wrap
// that lands while a refresh is already owed is simply absorbed.
module dram_refresh_timer #(
  parameter int REF_PERIOD = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic ref_take,
  output logic ref_pend
);

  localparam int CW = $clog2(REF_PERIOD + 1);
  localparam logic [CW-1:0] LAST = CW'(REF_PERIOD - 1);

  logic [CW-1:0] cnt_q;
  logic          pend_q;
  logic          wrap;

  assign wrap     = (cnt_q == LAST);
  assign ref_pend = pend_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q <= wrap ? '0 : cnt_q + CW'(1);
      // A fresh wrap wins over a take on the same edge so it is not lost.
      if (wrap)
        pend_q <= 1'b1;
      else if (ref_take)
        pend_q <= 1'b0;
    end
  end

endmodule

// File: rtl/dram_ctrl.sv
// dram_ctrl: single-word fast-page DRAM initiator with CBR refresh.
//   clk, rst         clock, asynchronous active-high reset
//   req, rnw, addr   host request ({bank,row,col}), 1 = read
//   wdata, be        write data and byte enables
//   busy, ack, rdata controller status, completion pulse, read data
//   ma, ras_n, cas_n, we_n, dq_out, dq_oe, dq_in   DRAM pins
// Access: IDLE -> ROW -> COL -> CAS -> PRE -> IDLE.
// Refresh: IDLE -> CBR_CAS -> CBR_RAS -> PRE -> IDLE.
// Every pin and ack/rdata comes straight from a flop.
module dram_ctrl
  import dram_ctrl_pkg::*;
#(
  parameter int AWID       = 10,
  parameter int BYTES      = 2,
  parameter int NUM_RAS    = 2,
  parameter int T_RCD      = 2,
  parameter int T_CAS      = 2,
  parameter int T_RP       = 2,
  parameter int T_RAS_CBR  = 3,
  parameter int REF_PERIOD = 256
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    req,
  input  logic                                    rnw,
  input  logic [2*AWID+$clog2(NUM_RAS)-1:0]       addr,
  input  logic [BYTES*8-1:0]                      wdata,
  input  logic [BYTES-1:0]                        be,
  output logic                                    busy,
  output logic                                    ack,
  output logic [BYTES*8-1:0]                      rdata,
  output logic [AWID-1:0]                         ma,
  output logic [NUM_RAS-1:0]                      ras_n,
  output logic [BYTES-1:0]                        cas_n,
  output logic                                    we_n,
  output logic [BYTES*8-1:0]                      dq_out,
  output logic                                    dq_oe,
  input  logic [BYTES*8-1:0]                      dq_in
);

  localparam int RWID = $clog2(NUM_RAS);
  localparam int DWID = BYTES * 8;

  // Terminal counts for the multi-cycle states (counter starts at 0).
  localparam logic [7:0] COL_LAST = 8'(T_RCD - 2);
  localparam logic [7:0] CAS_LAST = 8'(T_CAS - 1);
  localparam logic [7:0] PRE_LAST = 8'(T_RP - 1);
  localparam logic [7:0] CBR_LAST = 8'(T_RAS_CBR - 1);
  localparam logic [NUM_RAS-1:0] RAS_ONE = NUM_RAS'(1);

  state_t             state_q;
  logic [7:0]         cnt_q;
  logic               rnw_q;
  logic [AWID-1:0]    col_q;
  logic [DWID-1:0]    wdata_q;
  logic [BYTES-1:0]   be_q;
  logic               busy_q;
  logic               ack_q;
  logic [DWID-1:0]    rdata_q;
  logic [AWID-1:0]    ma_q;
  logic [NUM_RAS-1:0] ras_n_q;
  logic [BYTES-1:0]   cas_n_q;
  logic               we_n_q;
  logic [DWID-1:0]    dq_out_q;
  logic               dq_oe_q;

  logic               ref_pend;
  logic               ref_take;
  logic [AWID-1:0]    addr_row;
  logic [AWID-1:0]    addr_col;
  logic [RWID-1:0]    addr_bank;

  assign addr_row  = AWID'(dc_row(64'(addr), AWID));
  assign addr_col  = AWID'(dc_col(64'(addr), AWID));
  assign addr_bank = RWID'(dc_bank(64'(addr), AWID));

  // Refresh outranks a waiting host request whenever both meet in IDLE.
  assign ref_take = (state_q == ST_IDLE) && ref_pend;

  dram_refresh_timer #(
    .REF_PERIOD(REF_PERIOD)
  ) u_refresh_timer (
    .clk     (clk),
    .rst     (rst),
    .ref_take(ref_take),
    .ref_pend(ref_pend)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rnw_q    <= 1'b1;
      col_q    <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      ma_q     <= '0;
      ras_n_q  <= '1;
      cas_n_q  <= '1;
      we_n_q   <= 1'b1;
      dq_out_q <= '0;
      dq_oe_q  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ref_pend) begin
            cas_n_q <= '0;
            we_n_q  <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_CBR_CAS;
          end else if (req) begin
            rnw_q   <= rnw;
            col_q   <= addr_col;
            wdata_q <= wdata;
            be_q    <= be;
            ma_q    <= addr_row;
            ras_n_q <= ~(RAS_ONE << addr_bank);
            busy_q  <= 1'b1;
            state_q <= ST_ROW;
          end
        end
        ST_ROW: begin
          // Column goes out now so it has settled well before CAS falls.
          ma_q <= col_q;
          if (!rnw_q) begin
            we_n_q   <= 1'b0;
            dq_oe_q  <= 1'b1;
            dq_out_q <= wdata_q;
          end
          cnt_q   <= '0;
          state_q <= ST_COL;
        end
        ST_COL: begin
          if (cnt_q == COL_LAST) begin
            cas_n_q <= rnw_q ? '0 : ~be_q;
            cnt_q   <= '0;
            state_q <= ST_CAS;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_CAS: begin
          if (cnt_q == CAS_LAST) begin
            if (rnw_q)
              rdata_q <= dq_in;
            ras_n_q <= '1;
            cas_n_q <= '1;
            we_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
            ack_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_PRE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_PRE: begin
          if (cnt_q == PRE_LAST) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_CBR_CAS: begin
          ras_n_q <= '0;
          cnt_q   <= '0;
          state_q <= ST_CBR_RAS;
        end
        ST_CBR_RAS: begin
          if (cnt_q == CBR_LAST) begin
            ras_n_q <= '1;
            cas_n_q <= '1;
            cnt_q   <= '0;
            state_q <= ST_PRE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign ack    = ack_q;
  assign rdata  = rdata_q;
  assign ma     = ma_q;
  assign ras_n  = ras_n_q;
  assign cas_n  = cas_n_q;
  assign we_n   = we_n_q;
  assign dq_out = dq_out_q;
  assign dq_oe  = dq_oe_q;

endmodule

// File: tb/tb_dram_ctrl.sv
// Bench for dram_ctrl: behavioural DRAM array on the pins, a word-level
// reference memory for expected read data, and an ack-driven scoreboard.
module tb_dram_ctrl;

  localparam int AWID = 10, BYTES = 2, NUM_RAS = 2;
  localparam int T_RCD = 2, T_CAS = 2, T_RP = 2, T_RAS_CBR = 3, REF_PERIOD = 256;
  localparam int ADW = 2 * AWID + 1;
  localparam int ACC_PERIOD = T_RCD + T_CAS + 1 + T_RP;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req = 1'b0;
  logic              rnw = 1'b1;
  logic [ADW-1:0]    addr = '0;
  logic [15:0]       wdata = '0;
  logic [1:0]        be = '0;
  logic              busy, ack;
  logic [15:0]       rdata;
  logic [AWID-1:0]   ma;
  logic [1:0]        ras_n;
  logic [1:0]        cas_n;
  logic              we_n;
  logic [15:0]       dq_out;
  logic              dq_oe;
  logic [15:0]       dq_in = '0;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  dram_ctrl #(
    .AWID(AWID), .BYTES(BYTES), .NUM_RAS(NUM_RAS), .T_RCD(T_RCD), .T_CAS(T_CAS),
    .T_RP(T_RP), .T_RAS_CBR(T_RAS_CBR), .REF_PERIOD(REF_PERIOD)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .rnw(rnw), .addr(addr), .wdata(wdata), .be(be),
    .busy(busy), .ack(ack), .rdata(rdata), .ma(ma), .ras_n(ras_n), .cas_n(cas_n),
    .we_n(we_n), .dq_out(dq_out), .dq_oe(dq_oe), .dq_in(dq_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Initial array contents shared by the DRAM model and the reference.
  function automatic logic [15:0] init_val(input int a);
    return 16'(a * 37) ^ 16'h3C3C;
  endfunction

  function automatic int mk(input int b, input int r, input int c);
    return (b << 20) | (r << 10) | c;
  endfunction

  // ---------------- reference memory (word level) ----------------
  logic [15:0] ref_mem [int];

  function automatic logic [15:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // ---------------- behavioural DRAM on the pins ----------------
  logic [15:0]     dmem [int];
  logic [AWID-1:0] row_lat [NUM_RAS];
  logic [1:0]      ras_p = '1, cas_p = '1;
  logic [AWID-1:0] ma_p = '0;
  logic [1:0]      ras_fell = '0, cas_fell = '0;
  bit              chk_cbr = 0;
  int              cur_key = 0;
  int              cbr_q[$];

  function automatic logic [15:0] dram_rd(input int k);
    return dmem.exists(k) ? dmem[k] : init_val(k);
  endfunction

  always @(negedge clk) begin
    logic [1:0] fr, fc;
    logic [15:0] w;
    int bk;
    if (chk_cbr) begin
      chk_cbr = 0;
      check("cbr_ras_after_cas", {30'd0, ras_n}, 32'd0);
    end
    fr = ras_p & ~ras_n;
    fc = cas_p & ~cas_n;
    if (fr != 2'b00 && cas_n == 2'b11) begin
      for (int b = 0; b < NUM_RAS; b++) if (fr[b]) row_lat[b] = ma;
      ras_fell = fr;
      cas_fell = 2'b00;
    end
    if (fc != 2'b00) begin
      if (ras_n == 2'b11) begin
        check("cbr_all_cas", {30'd0, cas_n}, 32'd0);
        cbr_q.push_back(cyc);
        chk_cbr = 1;
      end else begin
        check("ma_setup", {22'd0, ma}, {22'd0, ma_p});
        cas_fell = cas_fell | fc;
        bk = ras_n[1] ? 0 : 1;
        cur_key = mk(bk, int'(row_lat[bk]), int'(ma));
        if (!we_n) begin
          check("dq_oe_on_write", {31'd0, dq_oe}, 32'd1);
          w = dram_rd(cur_key);
          if (fc[0]) w[7:0] = dq_out[7:0];
          if (fc[1]) w[15:8] = dq_out[15:8];
          dmem[cur_key] = w;
        end
      end
    end
    if (cas_n != 2'b11 && ras_n != 2'b11 && we_n) dq_in = dram_rd(cur_key);
    else dq_in = '0;
    ras_p = ras_n;
    cas_p = cas_n;
    ma_p = ma;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        rd;
    logic [15:0] exp;
    logic [15:0] alt;
    int          ack_cyc;
    logic [1:0]  cas_m;
    logic [1:0]  ras_m;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (!rst && ack) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ack: got ack=1, expected none (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("ack_cycle", cyc, mon_e.ack_cyc);
        check("ras_bank", {30'd0, ras_fell}, {30'd0, mon_e.ras_m});
        check("cas_bytes", {30'd0, cas_fell}, {30'd0, mon_e.cas_m});
        if (mon_e.rd)
          check("rdata", {31'd0, (rdata === mon_e.exp) || (rdata === mon_e.alt)}, 32'd1);
        if (mon_e.rd && rdata !== mon_e.exp && rdata !== mon_e.alt)
          $display("  rdata got %h, expected %h", rdata, mon_e.exp);
        $display("ack cyc=%0d %s rdata=%h exp=%h cas=%b", cyc, mon_e.rd ? "RD" : "WR",
                 rdata, mon_e.exp, cas_fell);
      end
    end
  end

  // ---------------- driver ----------------
  // Raises req and waits for the access to start (RAS falls after an IDLE
  // cycle); returns that cycle 1 number, or -1 on timeout.
  task automatic access(input logic r, input int a, input logic [15:0] wd,
                        input logic [1:0] b, input bit hold, output int acc);
    exp_t e;
    logic [15:0] old;
    bit seen_idle;
    rnw = r; addr = ADW'(a); wdata = wd; be = b; req = 1'b1;
    acc = -1;
    seen_idle = !busy;
    for (int k = 0; k < 300 && acc < 0; k++) begin
      @(negedge clk);
      if (busy && seen_idle && ras_n != 2'b11 && cas_n == 2'b11) acc = cyc;
      seen_idle = !busy;
    end
    if (acc < 0) begin
      check("accept_timeout", 32'd0, 32'd1);
      req = 1'b0;
      return;
    end
    if (!hold) req = 1'b0;
    old = ref_rd(a);
    e.rd = r;
    e.ack_cyc = acc + T_RCD + T_CAS;
    e.ras_m = 2'(1 << (a >> 20));
    e.cas_m = r ? 2'b11 : b;
    if (r) e.exp = old;
    else begin
      e.exp = {b[1] ? wd[15:8] : old[15:8], b[0] ? wd[7:0] : old[7:0]};
      ref_mem[a] = e.exp;
    end
    e.alt = e.exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      check("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc, L, a1, a2, a3, old;
    int pool[8];
    int accs[4];

    repeat (3) @(negedge clk);
    check("rst_ras_n", {30'd0, ras_n}, 32'h3);
    check("rst_cas_n", {30'd0, cas_n}, 32'h3);
    check("rst_we_n", {31'd0, we_n}, 32'd1);
    check("rst_ma", {22'd0, ma}, 32'd0);
    check("rst_dq_out", {16'd0, dq_out}, 32'd0);
    check("rst_rdata", {16'd0, rdata}, 32'd0);
    check("rst_dq_oe", {31'd0, dq_oe}, 32'd0);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    // Write then read back, bank 1.
    a1 = mk(1, 'h123, 'h045);
    access(1'b0, a1, 16'hBEEF, 2'b11, 0, acc);
    access(1'b1, a1, 16'h0000, 2'b00, 0, acc);
    drain();

    // Byte-lane write.
    a2 = mk(0, 'h02A, 'h01F);
    access(1'b0, a2, 16'h5555, 2'b11, 0, acc);
    access(1'b0, a2, 16'hAA00, 2'b10, 0, acc);
    access(1'b1, a2, 16'h0000, 2'b00, 0, acc);
    // No-byte write leaves memory untouched.
    a3 = mk(1, 'h3FF, 'h000);
    access(1'b0, a3, 16'h5555, 2'b11, 0, acc);
    access(1'b0, a3, 16'hFFFF, 2'b00, 0, acc);
    access(1'b1, a3, 16'h0000, 2'b00, 0, acc);
    drain();

    // Random traffic over a small address pool.
    for (int i = 0; i < 8; i++)
      pool[i] = mk(int'($urandom_range(0, 1)), int'($urandom_range(0, 1023)),
                   int'($urandom_range(0, 1023)));
    for (int i = 0; i < 30; i++)
      access(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], 16'($urandom),
             2'($urandom), 0, acc);
    drain();

    // Refresh period while idle.
    repeat (20) @(negedge clk);
    cbr_q.delete();
    for (int k = 0; k < 1000 && cbr_q.size() < 3; k++) @(negedge clk);
    if (cbr_q.size() < 3) begin
      check("refresh_count", cbr_q.size(), 32'd3);
      L = cyc;
    end else begin
      check("refresh_period0", cbr_q[1] - cbr_q[0], REF_PERIOD);
      check("refresh_period1", cbr_q[2] - cbr_q[1], REF_PERIOD);
      L = cbr_q[2];
    end

    // Request raised in the cycle the next refresh becomes pending.
    for (int k = 0; k < 400 && cyc < L + REF_PERIOD - 1; k++) @(negedge clk);
    access(1'b1, a1, 16'h0000, 2'b00, 0, acc);
    check("collision_cbr", cbr_q.size() > 0 ? cbr_q[$] : 0, L + REF_PERIOD);
    check("collision_accept", acc, L + REF_PERIOD + 1 + T_RAS_CBR + T_RP + 1);
    drain();

    // Back-to-back reads with req held high.
    for (int i = 0; i < 4; i++)
      access(1'b1, pool[$urandom_range(0, 7)], 16'h0000, 2'b00, i < 3, accs[i]);
    for (int i = 1; i < 4; i++) check("b2b_spacing", accs[i] - accs[i-1], ACC_PERIOD);
    drain();

    // Reset while a write is in its CAS phase.
    old = int'(ref_rd(a1));
    access(1'b0, a1, 16'h1357, 2'b11, 0, acc);
    for (int k = 0; k < 10 && cas_n == 2'b11; k++) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_ras_n", {30'd0, ras_n}, 32'h3);
    check("abort_cas_n", {30'd0, cas_n}, 32'h3);
    check("abort_we_n", {31'd0, we_n}, 32'd1);
    check("abort_dq_oe", {31'd0, dq_oe}, 32'd0);
    sb.delete();
    @(negedge clk);
    check("abort_no_ack", {31'd0, ack}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    access(1'b1, a1, 16'h0000, 2'b00, 0, acc);
    if (sb.size() > 0) sb[sb.size()-1].alt = 16'(old);
    drain();
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
